// File: rtl/lc3_pkg.sv
// Shared LC-3 opcode and control-field encodings for the decode stage
// and its field decoder.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_t;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    // First address-adder operand select
    localparam logic [1:0] PC1_NONE  = 2'b00;
    localparam logic [1:0] PC1_OFF9  = 2'b01;
    localparam logic [1:0] PC1_OFF6  = 2'b10;
    localparam logic [1:0] PC1_ZERO  = 2'b11;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

endpackage

// File: rtl/lc3_ctrl_decoder.sv
// Purely combinational opcode-to-control decoder; the decode stage
// registers its outputs.
module lc3_ctrl_decoder
    import lc3_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_bit5,
    output logic [1:0] o_alu_control,
    output logic [1:0] o_pcselect1,
    output logic       o_pcselect2,
    output logic       o_op2select,
    output logic [1:0] o_w_control,
    output logic       o_mem_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_pcselect1   = PC1_NONE;
        o_pcselect2   = 1'b0;
        o_op2select   = 1'b0;
        o_w_control   = WB_ALU;
        o_mem_control = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                o_alu_control = ALU_ADD;
                o_op2select   = ~i_bit5;
            end
            OP_AND: begin
                o_alu_control = ALU_AND;
                o_op2select   = ~i_bit5;
            end
            OP_NOT: begin
                o_alu_control = ALU_NOT;
                o_op2select   = 1'b1;
            end
            OP_BR, OP_ST: begin
                o_pcselect1 = PC1_OFF9;
                o_pcselect2 = 1'b1;
            end
            OP_LD: begin
                o_pcselect1 = PC1_OFF9;
                o_pcselect2 = 1'b1;
                o_w_control = WB_MEM;
            end
            OP_LDI: begin
                o_pcselect1   = PC1_OFF9;
                o_pcselect2   = 1'b1;
                o_w_control   = WB_MEM;
                o_mem_control = 1'b1;
            end
            OP_STI: begin
                o_pcselect1   = PC1_OFF9;
                o_pcselect2   = 1'b1;
                o_mem_control = 1'b1;
            end
            OP_LEA: begin
                o_pcselect1 = PC1_OFF9;
                o_pcselect2 = 1'b1;
                o_w_control = WB_PC;
            end
            OP_LDR: begin
                o_pcselect1 = PC1_OFF6;
                o_w_control = WB_MEM;
            end
            OP_STR: o_pcselect1 = PC1_OFF6;
            OP_JMP: o_pcselect1 = PC1_ZERO;
            // JSR, RTI, reserved and TRAP leave every control at zero
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3_decode_stage.sv
// LC-3 decode stage: captures the fetched word and its PC+1 on
// enable_decode and registers the decoded execute/writeback/memory controls.
module lc3_decode_stage
    import lc3_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic        out_enable_decode,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control
);

    logic [1:0] w_alu_control;
    logic [1:0] w_pcselect1;
    logic       w_pcselect2;
    logic       w_op2select;
    logic [1:0] w_w_control;
    logic       w_mem_control;

    logic        r_out_enable;
    logic [15:0] r_ir;
    logic [15:0] r_npc;
    logic [5:0]  r_e_control;
    logic [1:0]  r_w_control;
    logic        r_mem_control;

    lc3_ctrl_decoder u_ctrl_decoder (
        .i_opcode      (dout[15:12]),
        .i_bit5        (dout[5]),
        .o_alu_control (w_alu_control),
        .o_pcselect1   (w_pcselect1),
        .o_pcselect2   (w_pcselect2),
        .o_op2select   (w_op2select),
        .o_w_control   (w_w_control),
        .o_mem_control (w_mem_control)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_enable  <= 1'b0;
            r_ir          <= '0;
            r_npc         <= '0;
            r_e_control   <= '0;
            r_w_control   <= '0;
            r_mem_control <= 1'b0;
        end else begin
            r_out_enable <= enable_decode;
            if (enable_decode) begin
                r_ir          <= dout;
                r_npc         <= npc_in;
                r_e_control   <= {w_alu_control, w_pcselect1, w_pcselect2, w_op2select};
                r_w_control   <= w_w_control;
                r_mem_control <= w_mem_control;
            end
        end
    end

    assign out_enable_decode = r_out_enable;
    assign IR                = r_ir;
    assign npc_out           = r_npc;
    assign E_Control         = r_e_control;
    assign W_Control         = r_w_control;
    assign Mem_Control       = r_mem_control;

endmodule

// File: doc/lc3_decode_stage.md
LC3_DECODE_STAGE -- requirements
Module: lc3_decode_stage

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port enable_decode, input, 1 bit: capture strobe for a new instruction.
REQ-004 SHALL have port dout, input, 16 bits: instruction word from the fetch/memory side.
REQ-005 SHALL have port npc_in, input, 16 bits: PC+1 of the instruction on dout.
REQ-006 SHALL have port out_enable_decode, output, 1 bit: high when the outputs hold a newly captured instruction.
REQ-007 SHALL have port IR, output, 16 bits: the captured instruction.
REQ-008 SHALL have port npc_out, output, 16 bits: the captured npc_in.
REQ-009 SHALL have port E_Control, output, 6 bits: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
REQ-010 SHALL have port W_Control, output, 2 bits: writeback select, where 00 is ALU, 01 is memory and 10 is PC/LEA.
REQ-011 SHALL have port Mem_Control, output, 1 bit: indirect access (LDI/STI).

Function
REQ-012 SHALL register all outputs; there is no combinational path from any input to any output.
REQ-013 SHALL, on a rising edge with enable_decode=1, load IR<=dout and npc_out<=npc_in, and load the control fields decoded from dout[15:12]; latency is 1 cycle.
REQ-014 SHALL, on a rising edge with enable_decode=0, hold IR, npc_out, E_Control, W_Control and Mem_Control unchanged.
REQ-015 SHALL drive out_enable_decode to the value of enable_decode registered one cycle earlier, so it pulses for exactly 1 cycle per capture.
REQ-016 SHALL decode alu_control as follows: ADD(0001) gives 00, AND(0101) gives 01, NOT(1001) gives 10, and all other opcodes give 00.
REQ-017 SHALL decode op2select as follows: ADD and AND give the inverse of dout[5]; NOT gives 1; all other opcodes give 0.
REQ-018 SHALL decode pcselect1 and pcselect2 as follows:
- BR(0000), LD(0010), LDI(1010), ST(0011), STI(1011), LEA(1110): pcselect1=01, pcselect2=1.
- LDR(0110), STR(0111): pcselect1=10, pcselect2=0.
- JMP(1100): pcselect1=11, pcselect2=0.
- All other opcodes: pcselect1=00, pcselect2=0.
REQ-019 SHALL decode W_Control as follows: ADD, AND and NOT give 00; LD, LDR and LDI give 01; LEA gives 10; all other opcodes give 00.
REQ-020 SHALL set Mem_Control=1 for LDI and STI only.
REQ-021 SHALL, for unsupported opcodes (JSR 0100, RTI 1000, reserved 1101, TRAP 1111), capture IR and npc_out normally and set E_Control=0, W_Control=00 and Mem_Control=0.
REQ-022 SHALL use only the new dout/npc_in values when enable_decode is asserted on consecutive cycles, with no bubble inserted.
REQ-023 SHALL give reset priority over enable_decode when both are high on the same edge.

Reset
REQ-024 SHALL, on reset, clear IR, npc_out, E_Control, W_Control, Mem_Control and out_enable_decode to 0 on the same edge.
REQ-025 SHALL, on reset mid-stream, discard any instruction presented that cycle; the first capture after reset is the first edge with reset=0 and enable_decode=1.

Structure
REQ-026 SHALL take the opcode constants, the W_Control encodings, the pcselect1 encodings and the alu_control encodings from a shared package (lc3_pkg).
REQ-027 SHALL implement field decoding in a combinational sub-module, lc3_ctrl_decoder (input opcode and bit 5; outputs the four control groups), instantiated once; the registers stay in lc3_decode_stage.

Verification
REQ-028 SHALL cover ADD R1,R2,#3: dout=0x12A3, npc_in=0x3001, enable_decode=1 gives, next cycle, IR=0x12A3, npc_out=0x3001, E_Control=0x00, W_Control=00, Mem_Control=0, out_enable_decode=1.
REQ-029 SHALL cover AND R1,R2,R3: dout=0x5283 gives E_Control=0x11, W_Control=00; LDR R1,R2,#4 (dout=0x6284) gives E_Control=0x08, W_Control=01.
REQ-030 SHALL cover LDI: dout=0xA205 gives E_Control=0x06, W_Control=01, Mem_Control=1; LEA dout=0xE205 gives E_Control=0x06, W_Control=10.
REQ-031 SHALL cover holding: capture 0x12A3, then enable_decode=0 for 3 cycles with dout=0xFFFF, gives outputs held at 0x12A3 values and out_enable_decode=0 after the first cycle.
REQ-032 SHALL cover reset priority: reset=1 and enable_decode=1 with dout=0x5283 gives all outputs 0 next cycle; after reset is released, a capture behaves as in REQ-028.
REQ-033 SHALL cover an unsupported opcode and back-to-back captures: dout=0xF025 (TRAP) gives IR=0xF025 with all controls 0; back-to-back 0x12A3 then 0x6284 gives each value on consecutive cycles.
